// File: rtl/trap_controller_if.sv
// Bus bundle between the EX stage / CSR file and trap_controller.
// Carries the decoder event flags, the current CSR values, the pipeline CSR
// write request and the controller's CSR write port, flush/stall and redirect.
//
// Handshake: instr_valid_ex qualifies every EX-stage flag and pc_ex. The
// controller takes no event without it. There is no ready signal. The
// controller exerts back-pressure only through stall. redirect_valid is a
// single-cycle pulse and redirect_pc is meaningful only while it is high.
// csr_we is a single-cycle write strobe, with csr_waddr and csr_wdata valid
// in the same cycle.
interface trap_controller_if #(
  parameter int XLEN = 32
);
  logic            instr_valid_ex;
  logic [XLEN-1:0] pc_ex;
  logic            illegal_ex;
  logic            ecall_ex;
  logic            mret_ex;
  logic            irq_ext;
  logic            irq_timer;
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic            pipe_csr_we;
  logic [11:0]     pipe_csr_addr;
  logic [XLEN-1:0] pipe_csr_wdata;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            flush;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Pipeline / CSR-file side
  modport master (
    output instr_valid_ex, pc_ex, illegal_ex, ecall_ex, mret_ex,
    output irq_ext, irq_timer, mstatus_q, mie_q, mtvec_q, mepc_q,
    output pipe_csr_we, pipe_csr_addr, pipe_csr_wdata,
    input  csr_we, csr_waddr, csr_wdata, flush, stall,
    input  redirect_valid, redirect_pc
  );

  // Trap controller side
  modport slave (
    input  instr_valid_ex, pc_ex, illegal_ex, ecall_ex, mret_ex,
    input  irq_ext, irq_timer, mstatus_q, mie_q, mtvec_q, mepc_q,
    input  pipe_csr_we, pipe_csr_addr, pipe_csr_wdata,
    output csr_we, csr_waddr, csr_wdata, flush, stall,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap / interrupt sequencer.
//
// Detects exceptions, MRET and enabled interrupts on the EX-stage instruction.
// It then walks the mepc/mcause/mstatus save sequence, or the mstatus restore
// for MRET, over the CSR file's only write port, and finishes with a
// one-cycle PC redirect. When it is idle, the pipeline's CSR write request
// passes straight through.
//
// Optional build macro TRAP_VECTORED_EN: when it is defined, an interrupt
// with mtvec mode 2'b01 vectors to base + 4*cause.
module trap_controller #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  trap_controller_if.slave       bus,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SAVE_EPC    = 3'd1,
    S_SAVE_CAUSE  = 3'd2,
    S_SAVE_STATUS = 3'd3,
    S_RESTORE     = 3'd4,
    S_REDIRECT    = 3'd5
  } state_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  state_e          state_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] target_q;
  logic            seq_we_q;
  logic [11:0]     seq_addr_q;
  logic [XLEN-1:0] seq_wdata_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            ev_trap;
  logic            ev_mret;
  logic [XLEN-1:0] cause_d;
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] mstatus_trap_d;
  logic [XLEN-1:0] mstatus_mret_d;
  logic            ext_en;
  logic            tmr_en;

  assign ext_en = bus.irq_ext   & bus.mstatus_q[3] & bus.mie_q[11];
  assign tmr_en = bus.irq_timer & bus.mstatus_q[3] & bus.mie_q[7];

  // Prioritised event detection, only for a real instruction while idle
  always_comb begin
    ev_trap = 1'b0;
    ev_mret = 1'b0;
    cause_d = '0;
    if (state_q == S_IDLE && bus.instr_valid_ex) begin
      if (bus.illegal_ex) begin
        ev_trap = 1'b1;
        cause_d = XLEN'(32'd2);
      end else if (bus.ecall_ex) begin
        ev_trap = 1'b1;
        cause_d = XLEN'(32'd11);
      end else if (bus.mret_ex) begin
        ev_mret = 1'b1;
      end else if (ext_en) begin
        ev_trap = 1'b1;
        cause_d = XLEN'(32'h8000_000B);
      end else if (tmr_en) begin
        ev_trap = 1'b1;
        cause_d = XLEN'(32'h8000_0007);
      end
    end
  end

  // Trap target: aligned mtvec base, falling back to RESET_VECTOR when zero
  always_comb begin
    tvec_base = {bus.mtvec_q[XLEN-1:2], 2'b00};
    if (tvec_base == '0) tvec_base = RESET_VECTOR;
    target_d = tvec_base;
`ifdef TRAP_VECTORED_EN
    if (bus.mtvec_q[1:0] == 2'b01 && cause_d[XLEN-1])
      target_d = tvec_base + {cause_d[XLEN-3:0], 2'b00};
`endif
  end

  // mstatus images for trap entry and for MRET
  always_comb begin
    mstatus_trap_d        = bus.mstatus_q;
    mstatus_trap_d[7]     = bus.mstatus_q[3];
    mstatus_trap_d[3]     = 1'b0;
    mstatus_trap_d[12:11] = 2'b11;
    mstatus_mret_d        = bus.mstatus_q;
    mstatus_mret_d[3]     = bus.mstatus_q[7];
    mstatus_mret_d[7]     = 1'b1;
  end

  // Sequencer FSM with registered write-port and redirect outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      epc_q            <= '0;
      cause_q          <= '0;
      target_q         <= '0;
      seq_we_q         <= 1'b0;
      seq_addr_q       <= '0;
      seq_wdata_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      seq_we_q         <= 1'b0;
      seq_addr_q       <= '0;
      seq_wdata_q      <= '0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ev_trap) begin
            state_q    <= S_SAVE_EPC;
            epc_q      <= bus.pc_ex;
            cause_q    <= cause_d;
            target_q   <= target_d;
            seq_we_q   <= 1'b1;
            seq_addr_q <= ADDR_MEPC;
          end else if (ev_mret) begin
            state_q     <= S_RESTORE;
            target_q    <= bus.mepc_q;
            seq_we_q    <= 1'b1;
            seq_addr_q  <= ADDR_MSTATUS;
            seq_wdata_q <= mstatus_mret_d;
          end
        end
        S_SAVE_EPC: begin
          state_q     <= S_SAVE_CAUSE;
          seq_we_q    <= 1'b1;
          seq_addr_q  <= ADDR_MCAUSE;
          seq_wdata_q <= cause_q;
        end
        S_SAVE_CAUSE: begin
          state_q     <= S_SAVE_STATUS;
          seq_we_q    <= 1'b1;
          seq_addr_q  <= ADDR_MSTATUS;
          seq_wdata_q <= mstatus_trap_d;
        end
        S_SAVE_STATUS, S_RESTORE: begin
          state_q          <= S_REDIRECT;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= target_q;
        end
        S_REDIRECT: state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  // CSR write port: pipeline pass-through when idle and quiet, sequencer otherwise
  always_comb begin
    bus.csr_we    = 1'b0;
    bus.csr_waddr = '0;
    bus.csr_wdata = '0;
    if (state_q == S_IDLE) begin
      if (!ev_trap && !ev_mret) begin
        bus.csr_we    = bus.pipe_csr_we;
        bus.csr_waddr = bus.pipe_csr_addr;
        bus.csr_wdata = bus.pipe_csr_wdata;
      end
    end else begin
      bus.csr_we    = seq_we_q;
      bus.csr_waddr = seq_addr_q;
      bus.csr_wdata = (state_q == S_SAVE_EPC) ? {epc_q[XLEN-1:1], 1'b0} : seq_wdata_q;
    end
  end

  assign bus.stall          = (state_q != S_IDLE);
  assign bus.flush          = (state_q != S_IDLE) | ev_trap | ev_mret;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign dbg_state_o        = state_q;

  // Bits that no decision looks at
  logic unused_bits;
  assign unused_bits = ^{epc_q[0], bus.mtvec_q[1:0]};

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller. A transaction-level reference model predicts,
// for each cycle, either the idle behaviour (pass-through or event
// detection) or the next entry of a queue of expected write/redirect cycles.
module tb_trap_controller;

  localparam logic [31:0] RV = 32'h0000_1000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  trap_controller_if #(.XLEN(32)) bus();

  trap_controller #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // record: {we, addr[11:0], data[31:0], redirect_valid, redirect_pc[31:0]}
  logic [77:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference event decision, straight from the priority rules
  task automatic model_event(output int kind, output logic [31:0] cause);
    kind  = 0;
    cause = 32'h0;
    if (bus.instr_valid_ex) begin
      if (bus.illegal_ex)     begin kind = 1; cause = 32'd2;  end
      else if (bus.ecall_ex)  begin kind = 1; cause = 32'd11; end
      else if (bus.mret_ex)   begin kind = 2; end
      else if (bus.irq_ext && bus.mstatus_q[3] && bus.mie_q[11])  begin kind = 1; cause = 32'h8000_000B; end
      else if (bus.irq_timer && bus.mstatus_q[3] && bus.mie_q[7]) begin kind = 1; cause = 32'h8000_0007; end
    end
  endtask

  // One clock cycle: check outputs at negedge, advance the model, pass the edge
  task automatic cycle();
    logic [77:0] rec;
    logic [31:0] cause, base, tgt, st;
    int kind;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      rec = exp_q.pop_front();
      check_eq("busy_flush", bus.flush, 1);
      check_eq("busy_stall", bus.stall, 1);
      check_eq("busy_csr_we", bus.csr_we, rec[77]);
      if (rec[77]) begin
        check_eq("busy_csr_waddr", bus.csr_waddr, rec[76:65]);
        check_eq("busy_csr_wdata", bus.csr_wdata, rec[64:33]);
      end
      check_eq("busy_redir_v", bus.redirect_valid, rec[32]);
      if (rec[32]) check_eq("redir_pc", bus.redirect_pc, rec[31:0]);
    end else begin
      model_event(kind, cause);
      check_eq("idle_flush", bus.flush, (kind != 0));
      check_eq("idle_stall", bus.stall, 0);
      check_eq("idle_redir_v", bus.redirect_valid, 0);
      if (kind == 0) begin
        check_eq("pass_we", bus.csr_we, bus.pipe_csr_we);
        if (bus.pipe_csr_we) begin
          check_eq("pass_addr", bus.csr_waddr, bus.pipe_csr_addr);
          check_eq("pass_data", bus.csr_wdata, bus.pipe_csr_wdata);
        end
      end else begin
        check_eq("detect_masked_we", bus.csr_we, 0);
      end
      if (kind == 1) begin
        base = bus.mtvec_q & ~32'h3;
        if (base == 32'h0) base = RV;
        tgt = base;
`ifdef TRAP_VECTORED_EN
        if (bus.mtvec_q[1:0] == 2'b01 && cause[31]) tgt = base + 4 * (cause & 32'h7fff_ffff);
`endif
        st = (bus.mstatus_q & ~32'h0000_1888) | (bus.mstatus_q[3] ? 32'h80 : 32'h0) | 32'h1800;
        exp_q.push_back({1'b1, 12'h341, bus.pc_ex & ~32'h1, 1'b0, 32'h0});
        exp_q.push_back({1'b1, 12'h342, cause, 1'b0, 32'h0});
        exp_q.push_back({1'b1, 12'h300, st, 1'b0, 32'h0});
        exp_q.push_back({1'b0, 12'h000, 32'h0, 1'b1, tgt});
      end else if (kind == 2) begin
        st = (bus.mstatus_q & ~32'h88) | (bus.mstatus_q[7] ? 32'h8 : 32'h0) | 32'h80;
        exp_q.push_back({1'b1, 12'h300, st, 1'b0, 32'h0});
        exp_q.push_back({1'b0, 12'h000, 32'h0, 1'b1, bus.mepc_q});
      end
    end
    if (rst) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic clear_events();
    bus.illegal_ex = 1'b0;
    bus.ecall_ex   = 1'b0;
    bus.mret_ex    = 1'b0;
    bus.irq_ext    = 1'b0;
    bus.irq_timer  = 1'b0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.instr_valid_ex = 1'b0;
    bus.pc_ex          = 32'h0;
    clear_events();
    bus.mstatus_q      = 32'h0;
    bus.mie_q          = 32'h0;
    bus.mtvec_q        = 32'h0;
    bus.mepc_q         = 32'h0;
    bus.pipe_csr_we    = 1'b0;
    bus.pipe_csr_addr  = 12'h0;
    bus.pipe_csr_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    @(negedge clk);
    check_eq("rst_csr_we", bus.csr_we, 0);
    check_eq("rst_flush", bus.flush, 0);
    check_eq("rst_stall", bus.stall, 0);
    check_eq("rst_redir_v", bus.redirect_valid, 0);
    check_eq("rst_redir_pc", bus.redirect_pc, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_idle(2);

    // illegal at 0x100, mtvec 0x200, MIE=1
    bus.instr_valid_ex = 1'b1;
    bus.pc_ex = 32'h100; bus.mtvec_q = 32'h200; bus.mstatus_q = 32'h8;
    bus.illegal_ex = 1'b1;
    cycle();
    clear_events();
    run_idle(6);

    // ECALL with irq_ext: cause 11, then interrupt retaken after return
    bus.mie_q = 32'h800; bus.mstatus_q = 32'h8; bus.pc_ex = 32'h180;
    bus.ecall_ex = 1'b1; bus.irq_ext = 1'b1;
    cycle();
    bus.ecall_ex = 1'b0;
    run_idle(4);
    bus.mstatus_q = 32'h1880;          // after trap entry: MIE=0, MPIE=1
    run_idle(2);                       // pending irq, MIE=0: ignored
    bus.mepc_q = 32'h180; bus.mret_ex = 1'b1;
    cycle();
    bus.mret_ex = 1'b0;
    run_idle(2);
    bus.mstatus_q = 32'h88;            // after return: MIE=1
    run_idle(6);                       // irq_ext now taken
    clear_events();
    run_idle(2);

    // timer interrupt, mtvec vectored mode
    bus.mstatus_q = 32'h8; bus.mie_q = 32'h80; bus.mtvec_q = 32'h201; bus.pc_ex = 32'h44;
    bus.irq_timer = 1'b1;
    cycle();
    bus.irq_timer = 1'b0;
    run_idle(5);

    // MRET with MPIE=1
    bus.mstatus_q = 32'h80; bus.mepc_q = 32'h104; bus.mret_ex = 1'b1;
    cycle();
    bus.mret_ex = 1'b0;
    run_idle(3);

    // mtvec zero falls back to RESET_VECTOR; invalid instr with illegal ignored
    bus.mtvec_q = 32'h3; bus.instr_valid_ex = 1'b0; bus.illegal_ex = 1'b1;
    run_idle(2);
    bus.instr_valid_ex = 1'b1; bus.pc_ex = 32'h333;
    cycle();
    clear_events();
    run_idle(5);

    // interrupt with MIE=0 leaves pipeline alone
    bus.mstatus_q = 32'h0; bus.mie_q = 32'h880; bus.irq_ext = 1'b1; bus.irq_timer = 1'b1;
    run_idle(3);
    clear_events();

    // pipeline CSRRW passes through in idle, dropped during the sequence
    bus.pipe_csr_we = 1'b1; bus.pipe_csr_addr = 12'h340; bus.pipe_csr_wdata = 32'hAB;
    cycle();
    bus.mtvec_q = 32'h200; bus.pc_ex = 32'h208; bus.ecall_ex = 1'b1;
    cycle();
    bus.ecall_ex = 1'b0;
    run_idle(5);

    // reset during SAVE_CAUSE aborts the sequence
    bus.pipe_csr_we = 1'b0; bus.illegal_ex = 1'b1; bus.pc_ex = 32'h500;
    cycle();
    bus.illegal_ex = 1'b0;
    cycle();                           // SAVE_EPC
    rst = 1'b1;
    cycle();                           // SAVE_CAUSE, reset sampled
    rst = 1'b0;
    run_idle(4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) begin
        bus.mstatus_q = $urandom;
        bus.mie_q     = $urandom;
        bus.mepc_q    = $urandom;
        case ($urandom_range(0, 4))
          0:       bus.mtvec_q = 32'h0;
          1:       bus.mtvec_q = 32'h200;
          2:       bus.mtvec_q = 32'h201;
          3:       bus.mtvec_q = 32'h3;
          default: bus.mtvec_q = $urandom;
        endcase
      end
      bus.instr_valid_ex = ($urandom_range(0, 3) != 0);
      bus.pc_ex          = $urandom;
      bus.illegal_ex     = ($urandom_range(0, 15) == 0);
      bus.ecall_ex       = ($urandom_range(0, 15) == 0);
      bus.mret_ex        = ($urandom_range(0, 11) == 0);
      bus.irq_ext        = ($urandom_range(0, 5) == 0);
      bus.irq_timer      = ($urandom_range(0, 5) == 0);
      bus.pipe_csr_we    = $urandom_range(0, 1);
      bus.pipe_csr_addr  = 12'($urandom);
      bus.pipe_csr_wdata = $urandom;
      rst                = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0;
    clear_events();
    run_idle(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap and interrupt sequencer for the pipelined RV32 core.
- Sits beside the EX stage and consumes the decoder's illegal/ecall/mret flags and the external and timer interrupt lines.
- Owns the CSR file's single write port. It arbitrates between pipeline CSR instructions and its own multi-cycle mepc/mcause/mstatus update sequence, then issues the PC redirect.

Parameters:
- XLEN, 32, datapath and CSR width
- RESET_VECTOR, 32'h0000_0000, redirect target used if mtvec reads zero

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- instr_valid_ex  in  1  EX stage holds a valid, non-bubble instruction
- pc_ex  in  XLEN  PC of the EX-stage instruction
- illegal_ex  in  1  decoder flagged illegal opcode
- ecall_ex  in  1  ECALL in EX
- mret_ex  in  1  MRET in EX
- irq_ext  in  1  external interrupt, level
- irq_timer  in  1  timer interrupt, level
- mstatus_q  in  XLEN  current mstatus (MIE bit 3, MPIE bit 7)
- mie_q  in  XLEN  current mie (MEIE bit 11, MTIE bit 7)
- mtvec_q  in  XLEN  current mtvec
- mepc_q  in  XLEN  current mepc
- pipe_csr_we  in  1  pipeline CSR write request
- pipe_csr_addr  in  12  pipeline CSR address
- pipe_csr_wdata  in  XLEN  pipeline CSR data
- csr_we  out  1  CSR file write enable
- csr_waddr  out  12  CSR file write address
- csr_wdata  out  XLEN  CSR file write data
- flush  out  1  flush IF/ID/EX pipeline registers
- stall  out  1  freeze PC and pipeline
- redirect_valid  out  1  one-cycle PC load pulse
- redirect_pc  out  XLEN  new PC

Behaviour:
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, RESTORE, REDIRECT. Encoding is registered; reset puts the FSM in IDLE.
- Reset: all registered outputs are 0 and the internal target/cause/epc registers are 0. A reset mid-sequence aborts it immediately; no further CSR writes occur.
- Trap detection happens only in IDLE with instr_valid_ex=1. Priority, highest first:
  - illegal_ex: cause 2
  - ecall_ex: cause 11
  - mret_ex
  - irq_ext, when MIE & MEIE: cause 32'h8000_000B
  - irq_timer, when MIE & MTIE: cause 32'h8000_0007
- Trap taken, detection cycle T:
  - pc_ex and the cause are latched.
  - The pipeline write is masked: csr_we=0 even if pipe_csr_we=1.
  - The next state is SAVE_EPC.
- SAVE_EPC: csr_we=1, addr 12'h341, data = latched pc with bit 0 cleared.
- SAVE_CAUSE: addr 12'h342, data = latched cause.
- SAVE_STATUS: addr 12'h300, data = mstatus_q with MPIE←MIE, MIE←0, MPP[12:11]←2'b11.
- REDIRECT: redirect_valid=1 with redirect_pc = trap target, then IDLE. Total busy time is 4 cycles after T.
- MRET in IDLE goes to RESTORE. RESTORE writes mstatus with MIE←MPIE, MPIE←1 and latches the target = mepc_q. Then REDIRECT, then IDLE.
- Trap target is mtvec_q with bits [1:0] cleared. If that value is 0, the target is RESET_VECTOR.
- flush=1 and stall=1 in every non-IDLE state. flush is also 1 combinationally in the detection cycle.
- IDLE with no event: csr_we/addr/wdata pass pipe_csr_* through with zero latency.
- Non-IDLE: pipeline CSR requests are dropped. The instruction was flushed and will refetch.
- Events arriving in non-IDLE states are ignored. Level interrupts remain pending and are re-evaluated in IDLE.
- Events with instr_valid_ex=0 are not taken. This guarantees mepc always names a real instruction.
- Interrupt with MIE=0: no action, pipeline unaffected.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: when mtvec_q[1:0]==2'b01 and the cause is an interrupt, the target is base + 4×cause[30:0]. Exceptions still use base.
- Undefined: mtvec mode bits are ignored and all traps go to base.

Test Plan:
- Illegal at pc_ex=0x100, mtvec=0x200:
  - writes, in order: 341←0x100, 342←0x2, 300 with MIE=0/MPIE=old MIE
  - then redirect_pc=0x200 on the 4th cycle after detection; flush/stall high throughout
- ECALL and irq_ext same cycle, MIE=1/MEIE=1 -> mcause=11; the interrupt is retaken after return.
- irq_timer with MIE=1, MTIE=1, pc_ex=0x44 -> mcause=0x80000007, mepc=0x44. With the macro and mtvec=0x201, redirect_pc=0x21C.
- MRET with mepc=0x104, MPIE=1 -> single write 300 with MIE=1, then redirect_pc=0x104 after 2 cycles.
- Pipeline CSRRW (addr 0x340, data 0xAB) in IDLE passes through same cycle. The same request during SAVE_CAUSE is dropped.
- rst asserted during SAVE_CAUSE -> next cycle IDLE, csr_we=0, redirect_valid=0, no 300 write.
